// File: rtl/sc_field_serializer_pkg.sv
// Shared types and defaults for the field serializer: FSM state encoding,
// default word/field widths and the index-width helper.
package sc_field_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_DATAWIDTH  = 8;
  localparam int DEF_FIELDWIDTH = 4;

  // Index bus width: max(1, clog2(n)), so a 1-field word still has a 1-bit index
  function automatic int idx_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sc_field_serializer_if.sv
// Handshake bundle for sc_field_serializer: word input side and field output side.
// slave = serializer view, master = producer/consumer (environment) view.
interface sc_field_serializer_if
  import sc_field_pkg::*;
#(
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int FIELDWIDTH = DEF_FIELDWIDTH
) ();

  localparam int NUMFIELDS = DATAWIDTH / FIELDWIDTH;
  localparam int IDXW      = idx_width(NUMFIELDS);

  logic [DATAWIDTH-1:0]  SC_FIELDSER_data_InBUS;
  logic                  SC_FIELDSER_valid_In;
  logic                  SC_FIELDSER_ready_Out;
  logic [FIELDWIDTH-1:0] SC_FIELDSER_field_OutBUS;
  logic                  SC_FIELDSER_valid_Out;
  logic                  SC_FIELDSER_ready_In;
  logic                  SC_FIELDSER_last_Out;
  logic [IDXW-1:0]       SC_FIELDSER_index_OutBUS;
  logic [DATAWIDTH-1:0]  SC_FIELDSER_fields_OutBUS;

  modport slave (
    input  SC_FIELDSER_data_InBUS,
    input  SC_FIELDSER_valid_In,
    output SC_FIELDSER_ready_Out,
    output SC_FIELDSER_field_OutBUS,
    output SC_FIELDSER_valid_Out,
    input  SC_FIELDSER_ready_In,
    output SC_FIELDSER_last_Out,
    output SC_FIELDSER_index_OutBUS,
    output SC_FIELDSER_fields_OutBUS
  );

  modport master (
    output SC_FIELDSER_data_InBUS,
    output SC_FIELDSER_valid_In,
    input  SC_FIELDSER_ready_Out,
    input  SC_FIELDSER_field_OutBUS,
    input  SC_FIELDSER_valid_Out,
    output SC_FIELDSER_ready_In,
    input  SC_FIELDSER_last_Out,
    input  SC_FIELDSER_index_OutBUS,
    input  SC_FIELDSER_fields_OutBUS
  );

endinterface

// File: rtl/sc_field_serializer_mux.sv
// Combinational field selector: emission index -> FIELDWIDTH slice of the word.
// SC_FIELD_SERIALIZER_MSB_FIRST_EN reverses the emission order (MSB field first).
module sc_field_mux
  import sc_field_pkg::*;
#(
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int FIELDWIDTH = DEF_FIELDWIDTH,
  parameter int IDXW       = idx_width(DATAWIDTH / FIELDWIDTH)
) (
  input  logic [DATAWIDTH-1:0]  word,
  input  logic [IDXW-1:0]       index,
  output logic [FIELDWIDTH-1:0] field
);

  localparam int NUMFIELDS = DATAWIDTH / FIELDWIDTH;

  // Compare against every legal slot rather than using a variable part-select,
  // so an out-of-range index simply yields zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first; otherwise a path
    // that skips the assignment infers a latch.
    field = '0;
    for (int k = 0; k < NUMFIELDS; k++) begin
`ifdef SC_FIELD_SERIALIZER_MSB_FIRST_EN
      if (index == IDXW'(k)) field = word[(NUMFIELDS-1-k)*FIELDWIDTH +: FIELDWIDTH];
`else
      if (index == IDXW'(k)) field = word[k*FIELDWIDTH +: FIELDWIDTH];
`endif
    end
  end

endmodule

// File: rtl/sc_field_serializer.sv
// Word-to-field serializer: accepts a DATAWIDTH word, emits NUMFIELDS fields with
// valid/ready, index and last. Order selectable with SC_FIELD_SERIALIZER_MSB_FIRST_EN.
module sc_field_serializer
  import sc_field_pkg::*;
#(
  parameter int DATAWIDTH  = DEF_DATAWIDTH,
  parameter int FIELDWIDTH = DEF_FIELDWIDTH
) (
  input  logic                SC_FIELDSER_CLOCK_50,
  input  logic                SC_FIELDSER_RESET_InLow,
  sc_field_serializer_if.slave bus
);

  localparam int NUMFIELDS = DATAWIDTH / FIELDWIDTH;
  localparam int IDXW      = idx_width(NUMFIELDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUMFIELDS - 1);

  if ((FIELDWIDTH < 1) || (DATAWIDTH % FIELDWIDTH != 0)) begin : g_bad_split
    $error("sc_field_serializer: DATAWIDTH must be a multiple of FIELDWIDTH");
  end
  if (NUMFIELDS < 2) begin : g_too_few_fields
    $error("sc_field_serializer: at least two fields per word are required");
  end

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [DATAWIDTH-1:0]  word_q, word_d;
  logic [FIELDWIDTH-1:0] field_q, field_d;
  logic                  valid_q, last_q;
  logic                  ready, in_xfer, out_xfer;

  // Accept in IDLE, or while the last field leaves, so words stream without a bubble
  assign ready    = (state_q == ST_IDLE) || (last_q && bus.SC_FIELDSER_ready_In);
  assign in_xfer  = bus.SC_FIELDSER_valid_In && ready;
  assign out_xfer = valid_q && bus.SC_FIELDSER_ready_In;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (in_xfer) begin
      state_d = ST_SHIFT;
      idx_d   = '0;
      word_d  = bus.SC_FIELDSER_data_InBUS;
    end else if (out_xfer) begin
      if (last_q) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end
  end

  // Select from the next word/index so the field register lines up with them
  sc_field_mux #(
    .DATAWIDTH (DATAWIDTH),
    .FIELDWIDTH(FIELDWIDTH),
    .IDXW      (IDXW)
  ) u_mux (
    .word (word_d),
    .index(idx_d),
    .field(field_d)
  );

  // NOTE: reset is synchronous, so it is tested inside the clocked block and the
  // sensitivity list holds only the clock edge; the word register is reset too
  // because its value is visible on fields_OutBUS.
  always_ff @(posedge SC_FIELDSER_CLOCK_50) begin
    if (!SC_FIELDSER_RESET_InLow) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      field_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      field_q <= field_d;
      valid_q <= (state_d == ST_SHIFT);
      last_q  <= (state_d == ST_SHIFT) && (idx_d == LAST_IDX);
    end
  end

  assign bus.SC_FIELDSER_ready_Out     = ready;
  assign bus.SC_FIELDSER_field_OutBUS  = field_q;
  assign bus.SC_FIELDSER_valid_Out     = valid_q;
  assign bus.SC_FIELDSER_last_Out      = last_q;
  assign bus.SC_FIELDSER_index_OutBUS  = idx_q;
  assign bus.SC_FIELDSER_fields_OutBUS = word_q;

endmodule
